// File: rtl/pc_gen_pkg.sv
// Shared definitions for the IF-stage program-counter unit.
package pc_gen_pkg;

  // Source of the most recent PC load, as reported on redirect_o.
  typedef enum logic [1:0] {
    REDIR_SEQ = 2'd0,
    REDIR_ID  = 2'd1,
    REDIR_BR  = 2'd2,
    REDIR_EXC = 2'd3
  } redir_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0100;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. ptr_q is the next write slot, so the top
// entry lives at ptr_q-1. When full, a push overwrites the oldest entry and
// the count stays saturated.
module pc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    top_idx;
  logic [PW-1:0]    wr_idx;
  logic             wr_en;
  logic [WIDTH-1:0] mem_q [RAS_DEPTH];

  assign top_idx = ptr_q - PW'(1);
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DEPTH_C);
  assign top_o   = mem_q[top_idx];

  // Pointer/count update and write-slot selection for push, pop and replace.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (push_i && pop_i) begin
      // Return followed by call: replace the top, or seed an empty stack.
      wr_en = 1'b1;
      if (empty_o) begin
        wr_idx = ptr_q;
        ptr_d  = ptr_q + PW'(1);
        cnt_d  = CW'(1);
      end else begin
        wr_idx = top_idx;
      end
    end else if (push_i) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
      ptr_d  = ptr_q + PW'(1);
      if (!full_o) cnt_d = cnt_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Stack pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are meaningless while the count says empty.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with prioritised next-PC selection and an ID-stage
// return-address stack. All outputs are registered.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               INSTR_BYTES  = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             exc_valid_i,
  input  logic             br_valid_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             jmp_valid_i,
  input  logic [WIDTH-1:0] jmp_target_i,
  input  logic             call_i,
  input  logic [WIDTH-1:0] ret_addr_i,
  input  logic             ret_i,
  input  logic [WIDTH-1:0] ret_fallback_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             pc_valid_o,
  output logic [1:0]       redirect_o,
  output logic             ras_empty_o,
  output logic             ras_full_o
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q, valid_d;
  redir_e           redir_q, redir_d;

  logic             id_kill;
  logic             ras_push, ras_pop;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] ret_target;

  // A stalled or flushed ID instruction must not touch the stack.
  assign id_kill    = stall_i | br_valid_i | exc_valid_i;
  assign ras_push   = start_i & call_i & ~id_kill;
  assign ras_pop    = start_i & ret_i & ~id_kill;
  assign ret_target = ras_empty_o ? ret_fallback_i : ras_top;

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (~start_i),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (ret_addr_i),
    .top_o   (ras_top),
    .empty_o (ras_empty_o),
    .full_o  (ras_full_o)
  );

  // Next-PC priority: exception, branch, stall, return, jump, sequential.
  always_comb begin
    pc_d    = pc_q;
    valid_d = 1'b0;
    redir_d = REDIR_SEQ;
    if (!start_i) begin
      pc_d = RESET_VECTOR;
    end else begin
      valid_d = ~stall_i;
      if (exc_valid_i) begin
        pc_d    = EXC_VECTOR;
        redir_d = REDIR_EXC;
      end else if (br_valid_i) begin
        pc_d    = br_target_i;
        redir_d = REDIR_BR;
      end else if (stall_i) begin
        pc_d    = pc_q;
      end else if (ret_i) begin
        pc_d    = ret_target;
        redir_d = REDIR_ID;
      end else if (jmp_valid_i) begin
        pc_d    = jmp_target_i;
        redir_d = REDIR_ID;
      end else begin
        pc_d    = pc_q + WIDTH'(INSTR_BYTES);
      end
    end
  end

  // PC, fetch-valid and redirect-source registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      redir_q <= REDIR_SEQ;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      redir_q <= redir_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_valid_o = valid_q;
  assign redirect_o = redir_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus a randomized run,
// all compared against a queue-based reference model of the fetch PC and RAS.
module tb_pc_gen;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        exc_valid_i = 1'b0;
  logic        br_valid_i = 1'b0;
  logic [31:0] br_target_i = '0;
  logic        jmp_valid_i = 1'b0;
  logic [31:0] jmp_target_i = '0;
  logic        call_i = 1'b0;
  logic [31:0] ret_addr_i = '0;
  logic        ret_i = 1'b0;
  logic [31:0] ret_fallback_i = '0;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic [1:0]  redirect_o;
  logic        ras_empty_o;
  logic        ras_full_o;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_pc = 32'h0;
  logic        m_valid = 1'b0;
  logic [1:0]  m_redir = 2'd0;
  logic [31:0] m_ras[$];

  pc_gen dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .stall_i        (stall_i),
    .exc_valid_i    (exc_valid_i),
    .br_valid_i     (br_valid_i),
    .br_target_i    (br_target_i),
    .jmp_valid_i    (jmp_valid_i),
    .jmp_target_i   (jmp_target_i),
    .call_i         (call_i),
    .ret_addr_i     (ret_addr_i),
    .ret_i          (ret_i),
    .ret_fallback_i (ret_fallback_i),
    .pc_o           (pc_o),
    .pc_valid_o     (pc_valid_o),
    .redirect_o     (redirect_o),
    .ras_empty_o    (ras_empty_o),
    .ras_full_o     (ras_full_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void model_reset();
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_redir = 2'd0;
    m_ras.delete();
  endfunction

  // Next state of the model from the inputs currently applied.
  function automatic void model_step();
    logic        kill;
    logic [31:0] top;
    if (!start_i) begin
      model_reset();
      return;
    end
    kill    = stall_i | br_valid_i | exc_valid_i;
    top     = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : ret_fallback_i;
    m_valid = !stall_i;
    if (exc_valid_i)      begin m_pc = 32'h100;       m_redir = 2'd3; end
    else if (br_valid_i)  begin m_pc = br_target_i;   m_redir = 2'd2; end
    else if (stall_i)     begin                       m_redir = 2'd0; end
    else if (ret_i)       begin m_pc = top;           m_redir = 2'd1; end
    else if (jmp_valid_i) begin m_pc = jmp_target_i;  m_redir = 2'd1; end
    else                  begin m_pc = m_pc + 32'd4;  m_redir = 2'd0; end
    if (!kill) begin
      if (call_i && ret_i) begin
        if (m_ras.size() > 0) m_ras[m_ras.size()-1] = ret_addr_i;
        else m_ras.push_back(ret_addr_i);
      end else if (call_i) begin
        m_ras.push_back(ret_addr_i);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end else if (ret_i && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
  endfunction

  task automatic idle();
    stall_i = 0; exc_valid_i = 0; br_valid_i = 0; jmp_valid_i = 0;
    call_i = 0; ret_i = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || redirect_o !== 2'd0 ||
        ras_empty_o !== 1'b1 || ras_full_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: pc=%h valid=%b redir=%0d empty=%b full=%b, want 0 0 0 1 0",
               pc_o, pc_valid_o, redirect_o, ras_empty_o, ras_full_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    // Activity on other inputs must be ignored while start_i is low.
    for (int i = 0; i < 3; i++) begin
      call_i = 1; jmp_valid_i = 1; jmp_target_i = 32'h40; ret_addr_i = 32'h4;
      tick();
      checks++;
      if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || ras_empty_o !== 1'b1) begin
        errors++;
        $display("FAIL start_low_hold: pc=%h valid=%b empty=%b, want 0 0 1",
                 pc_o, pc_valid_o, ras_empty_o);
      end
    end
    idle();
    start_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (pc_o !== 32'(4*k) || pc_valid_o !== 1'b1 || redirect_o !== 2'd0) begin
        errors++;
        $display("FAIL start_seq: pc=%h valid=%b redir=%0d, want %h 1 0",
                 pc_o, pc_valid_o, redirect_o, 32'(4*k));
      end
    end
  endtask

  task automatic test_stall_branch();
    tick();
    for (int i = 0; i < 2; i++) begin
      stall_i = 1;
      tick();
      checks++;
      if (pc_o !== 32'h10 || pc_valid_o !== 1'b0 || redirect_o !== 2'd0) begin
        errors++;
        $display("FAIL stall_hold: pc=%h valid=%b redir=%0d, want 10 0 0",
                 pc_o, pc_valid_o, redirect_o);
      end
    end
    br_valid_i = 1; br_target_i = 32'h80;
    tick();
    checks++;
    if (pc_o !== 32'h80 || redirect_o !== 2'd2) begin
      errors++;
      $display("FAIL stall_vs_branch: pc=%h redir=%0d, want 80 2", pc_o, redirect_o);
    end
    idle();
  endtask

  task automatic test_exception();
    call_i = 1; ret_addr_i = 32'h5c;
    tick();
    idle();
    exc_valid_i = 1; br_valid_i = 1; br_target_i = 32'h200;
    jmp_valid_i = 1; jmp_target_i = 32'h300; call_i = 1; ret_addr_i = 32'h77c; ret_i = 1;
    tick();
    checks++;
    if (pc_o !== 32'h100 || redirect_o !== 2'd3 || ras_empty_o !== 1'b0) begin
      errors++;
      $display("FAIL exc_priority: pc=%h redir=%0d empty=%b, want 100 3 0",
               pc_o, redirect_o, ras_empty_o);
    end
    idle();
    ret_i = 1; ret_fallback_i = 32'h900;
    tick();
    checks++;
    if (pc_o !== 32'h5c || redirect_o !== 2'd1 || ras_empty_o !== 1'b1) begin
      errors++;
      $display("FAIL exc_ras_intact: pc=%h redir=%0d empty=%b, want 5c 1 1",
               pc_o, redirect_o, ras_empty_o);
    end
    idle();
  endtask

  task automatic test_ras_push_pop();
    logic [31:0] exp_pc [5] = '{32'h0, 32'h0, 32'h48, 32'h24, 32'h300};
    for (int i = 0; i < 5; i++) begin
      idle();
      ret_fallback_i = 32'h300;
      if (i == 0) begin call_i = 1; ret_addr_i = 32'h24; end
      else if (i == 1) begin call_i = 1; ret_addr_i = 32'h48; end
      else ret_i = 1;
      tick();
      checks++;
      if (pc_o !== m_pc || (i >= 2 && pc_o !== exp_pc[i]) ||
          ras_empty_o !== (m_ras.size() == 0)) begin
        errors++;
        $display("FAIL ras_push_pop[%0d]: pc=%h empty=%b, want %h %b",
                 i, pc_o, ras_empty_o, m_pc, m_ras.size() == 0);
      end
    end
    idle();
  endtask

  task automatic test_overflow();
    logic [31:0] vals [5] = '{32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'hE0};
    logic [31:0] pops [5] = '{32'hE0, 32'hD0, 32'hC0, 32'hB0, 32'hF00};
    for (int i = 0; i < 5; i++) begin
      call_i = 1; ret_addr_i = vals[i];
      tick();
    end
    checks++;
    if (ras_full_o !== 1'b1 || ras_empty_o !== 1'b0) begin
      errors++;
      $display("FAIL ras_full: full=%b empty=%b, want 1 0", ras_full_o, ras_empty_o);
    end
    idle();
    ret_fallback_i = 32'hF00;
    for (int i = 0; i < 5; i++) begin
      ret_i = 1;
      tick();
      checks++;
      if (pc_o !== pops[i] || pc_o !== m_pc || ras_full_o !== 1'b0) begin
        errors++;
        $display("FAIL ras_overflow_pop[%0d]: pc=%h full=%b, want %h 0",
                 i, pc_o, ras_full_o, pops[i]);
      end
    end
    idle();
  endtask

  task automatic test_wrap_suppress();
    jmp_valid_i = 1; jmp_target_i = 32'hFFFF_FFFC;
    tick();
    idle();
    tick();
    checks++;
    if (pc_o !== 32'h0 || redirect_o !== 2'd0) begin
      errors++;
      $display("FAIL pc_wrap: pc=%h redir=%0d, want 0 0", pc_o, redirect_o);
    end
    stall_i = 1; call_i = 1; ret_addr_i = 32'h444;
    tick();
    checks++;
    if (ras_empty_o !== 1'b1 || pc_o !== 32'h0) begin
      errors++;
      $display("FAIL call_suppressed: empty=%b pc=%h, want 1 0", ras_empty_o, pc_o);
    end
    idle();
    call_i = 1; ret_i = 1; ret_addr_i = 32'h888; ret_fallback_i = 32'h600;
    tick();
    checks++;
    if (pc_o !== 32'h600 || redirect_o !== 2'd1 || ras_empty_o !== 1'b0) begin
      errors++;
      $display("FAIL call_ret_empty: pc=%h redir=%0d empty=%b, want 600 1 0",
               pc_o, redirect_o, ras_empty_o);
    end
    idle();
    ret_i = 1; ret_fallback_i = 32'h604;
    tick();
    checks++;
    if (pc_o !== 32'h888 || ras_empty_o !== 1'b1) begin
      errors++;
      $display("FAIL call_ret_count1: pc=%h empty=%b, want 888 1", pc_o, ras_empty_o);
    end
    idle();
  endtask

  task automatic test_start_and_async_reset();
    for (int i = 0; i < 2; i++) begin
      call_i = 1; ret_addr_i = 32'h1000 + 32'(i*4);
      tick();
    end
    idle();
    start_i = 0;
    tick();
    checks++;
    if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || ras_empty_o !== 1'b1) begin
      errors++;
      $display("FAIL start_deassert: pc=%h valid=%b empty=%b, want 0 0 1",
               pc_o, pc_valid_o, ras_empty_o);
    end
    start_i = 1;
    call_i = 1; ret_addr_i = 32'h2000;
    tick(); tick();
    idle();
    #2 rst_i = 0;
    #1;
    model_reset();
    checks++;
    if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || ras_empty_o !== 1'b1 || ras_full_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pc=%h valid=%b empty=%b full=%b, want 0 0 1 0",
               pc_o, pc_valid_o, ras_empty_o, ras_full_o);
    end
    @(negedge clk_i);
    rst_i = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      start_i        = ($urandom_range(0, 49) != 0);
      stall_i        = ($urandom_range(0, 4) == 0);
      exc_valid_i    = ($urandom_range(0, 19) == 0);
      br_valid_i     = ($urandom_range(0, 9) == 0);
      jmp_valid_i    = ($urandom_range(0, 5) == 0);
      call_i         = ($urandom_range(0, 3) == 0);
      ret_i          = ($urandom_range(0, 3) == 0);
      br_target_i    = $urandom() & 32'hFFFF_FFFC;
      jmp_target_i   = $urandom() & 32'hFFFF_FFFC;
      ret_addr_i     = $urandom() & 32'hFFFF_FFFC;
      ret_fallback_i = $urandom() & 32'hFFFF_FFFC;
      tick();
      checks++;
      if (pc_o !== m_pc || pc_valid_o !== m_valid || redirect_o !== m_redir ||
          ras_empty_o !== (m_ras.size() == 0) || ras_full_o !== (m_ras.size() == DEPTH)) begin
        errors++;
        $display("FAIL random[%0d]: pc=%h/%h valid=%b/%b redir=%0d/%0d empty=%b/%b full=%b/%b",
                 i, pc_o, m_pc, pc_valid_o, m_valid, redirect_o, m_redir,
                 ras_empty_o, m_ras.size() == 0, ras_full_o, m_ras.size() == DEPTH);
      end
    end
    idle();
    start_i = 1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stall_branch();
    test_exception();
    test_ras_push_pop();
    test_overflow();
    test_wrap_suppress();
    test_start_and_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
